// File: rtl/vc_to_vr_converter.sv
// rtl/vc_to_vr_converter.sv - credit-based sender to valid/ready receiver bridge
module vc_to_vr_converter #(
    parameter int DATA_WIDTH = 8,
    parameter int CREDIT_NUM = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_credit_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i
);

    localparam int PTR_W = (CREDIT_NUM > 1) ? $clog2(CREDIT_NUM) : 1;
    localparam int CNT_W = $clog2(CREDIT_NUM + 1);

    logic [DATA_WIDTH-1:0] mem [CREDIT_NUM];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occ;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W:0]        avail;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(CREDIT_NUM - 1))
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    always_comb begin
        empty     = (occ == '0);
        full      = (occ == CNT_W'(CREDIT_NUM));
        pop       = !empty && m_ready_i;
        // A push into a full FIFO is only accepted when the head leaves on the same edge
        push      = s_valid_i && (!full || pop);
        m_valid_o = !empty;
        m_data_o  = empty ? '0 : mem[rd_ptr];
        avail     = {1'b0, cnt} + {{CNT_W{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Pending credits drain one per cycle; a pop can be returned on the very next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= CNT_W'(CREDIT_NUM);
            s_credit_o <= 1'b0;
        end else if (avail != '0) begin
            cnt        <= CNT_W'(avail - 1'b1);
            s_credit_o <= 1'b1;
        end else begin
            cnt        <= CNT_W'(avail);
            s_credit_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vc_to_vr_converter.sv
// tb/tb_vc_to_vr_converter.sv - randomized self-checking bench for vc_to_vr_converter
module tb_vc_to_vr_converter;

    localparam int DW = 8;
    localparam int CN = 2;

    logic          clk_tb = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data_i;
    logic          s_valid_i;
    logic          s_credit_o;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    int            mcnt;
    int            sender_credits;
    logic          exp_credit;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          sent;

    always #5 clk_tb = ~clk_tb;

    vc_to_vr_converter #(.DATA_WIDTH(DW), .CREDIT_NUM(CN)) dut (
        .clk        (clk_tb),
        .rst        (rst),
        .s_data_i   (s_data_i),
        .s_valid_i  (s_valid_i),
        .s_credit_o (s_credit_o),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i)
    );

    // One clock of the sender/receiver environment plus the reference model.
    // The sender only sends when it holds a credit.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        logic pop_m;
        int   avail;
        if (v && sender_credits == 0)
            v = 1'b0;
        sent      = v;
        s_valid_i = v;
        s_data_i  = d;
        m_ready_i = r;
        @(posedge clk_tb);
        pop_m      = (q.size() > 0) && r;
        avail      = mcnt + (pop_m ? 1 : 0);
        exp_credit = (avail > 0);
        mcnt       = (avail > 0) ? avail - 1 : avail;
        if (pop_m)
            void'(q.pop_front());
        if (v) begin
            q.push_back(d);
            sender_credits--;
        end
        if (exp_credit)
            sender_credits++;
        exp_valid = (q.size() > 0);
        exp_data  = exp_valid ? q[0] : '0;
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        mcnt           = CN;
        sender_credits = 0;
        exp_credit     = 1'b0;
        exp_valid      = 1'b0;
        exp_data       = '0;
    endtask

    task automatic test_reset();
        logic exp_seq [3];
        exp_seq = '{1'b1, 1'b1, 1'b0};
        rst       = 1'b1;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        m_ready_i = 1'b0;
        model_reset();
        @(posedge clk_tb);
        #1;
        checks++;
        if ({m_valid_o, s_credit_o, m_data_o} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_outputs got valid=%0b credit=%0b data=%h exp 0/0/00", m_valid_o, s_credit_o, m_data_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0);
            checks++;
            if (s_credit_o !== exp_seq[i]) begin
                failures++;
                $display("FAIL reset_credit_%0d got %0b exp %0b", i, s_credit_o, exp_seq[i]);
            end
            checks++;
            if (m_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid_%0d got %0b exp 0", i, m_valid_o);
            end
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] din  [3];
        logic          vin  [3];
        for (int i = 0; i < 3; i++) begin
            vin[i] = (i == 0);
            din[i] = (i == 0) ? 8'hAA : 8'h00;
        end
        for (int i = 0; i < 3; i++) begin
            step(vin[i], din[i], 1'b1);
            checks++;
            if (m_valid_o !== exp_valid || (exp_valid && m_data_o !== exp_data)) begin
                failures++;
                $display("FAIL single_data_%0d got v=%0b d=%h exp v=%0b d=%h", i, m_valid_o, m_data_o, exp_valid, exp_data);
            end
            checks++;
            if (s_credit_o !== exp_credit) begin
                failures++;
                $display("FAIL single_credit_%0d got %0b exp %0b", i, s_credit_o, exp_credit);
            end
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] din [4];
        din = '{8'hBB, 8'hCC, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            step(i < 2, din[i], 1'b0);
            checks++;
            if (m_valid_o !== 1'b1 || m_data_o !== 8'hBB) begin
                failures++;
                $display("FAIL stall_hold_%0d got v=%0b d=%h exp v=1 d=bb", i, m_valid_o, m_data_o);
            end
            checks++;
            if (s_credit_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_credit_%0d got %0b exp 0", i, s_credit_o);
            end
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (m_valid_o !== exp_valid || (exp_valid && m_data_o !== exp_data)) begin
                failures++;
                $display("FAIL drain_data_%0d got v=%0b d=%h exp v=%0b d=%h", i, m_valid_o, m_data_o, exp_valid, exp_data);
            end
            checks++;
            if (s_credit_o !== exp_credit) begin
                failures++;
                $display("FAIL drain_credit_%0d got %0b exp %0b", i, s_credit_o, exp_credit);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_sent = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b1);
            if (sent)
                n_sent++;
            checks++;
            if (m_valid_o !== exp_valid || (exp_valid && m_data_o !== exp_data)) begin
                failures++;
                $display("FAIL b2b_data_%0d got v=%0b d=%h exp v=%0b d=%h", i, m_valid_o, m_data_o, exp_valid, exp_data);
            end
            checks++;
            if (s_credit_o !== exp_credit) begin
                failures++;
                $display("FAIL b2b_credit_%0d got %0b exp %0b", i, s_credit_o, exp_credit);
            end
        end
        checks++;
        if (n_sent != 16) begin
            failures++;
            $display("FAIL b2b_throughput got %0d words exp 16", n_sent);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0);
            checks++;
            if (m_valid_o !== exp_valid || (exp_valid && m_data_o !== exp_data)) begin
                failures++;
                $display("FAIL rand_data_%0d got v=%0b d=%h exp v=%0b d=%h", i, m_valid_o, m_data_o, exp_valid, exp_data);
            end
            checks++;
            if (s_credit_o !== exp_credit) begin
                failures++;
                $display("FAIL rand_credit_%0d got %0b exp %0b", i, s_credit_o, exp_credit);
            end
        end
        for (int i = 0; i < 4; i++)
            step(1'b0, '0, 1'b1);
        checks++;
        if (m_valid_o !== 1'b0 || sender_credits != CN) begin
            failures++;
            $display("FAIL rand_final got v=%0b credits=%0d exp v=0 credits=%0d", m_valid_o, sender_credits, CN);
        end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 8'h5A, 1'b0);
        checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== 8'h5A) begin
            failures++;
            $display("FAIL midrst_load got v=%0b d=%h exp v=1 d=5a", m_valid_o, m_data_o);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({m_valid_o, s_credit_o, m_data_o} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL midrst_async got valid=%0b credit=%0b data=%h exp 0/0/00", m_valid_o, s_credit_o, m_data_o);
        end
        @(posedge clk_tb);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0);
            checks++;
            if (s_credit_o !== (i < 2)) begin
                failures++;
                $display("FAIL midrst_credit_%0d got %0b exp %0b", i, s_credit_o, i < 2);
            end
        end
        step(1'b1, 8'hFF, 1'b0);
        checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== 8'hFF) begin
            failures++;
            $display("FAIL midrst_ff got v=%0b d=%h exp v=1 d=ff", m_valid_o, m_data_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_drain();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
